pwm8_servo_core: RTL and testbench



---
 rtl/pwm8_pkg.sv | 28 ++
 rtl/pwm8_timebase.sv | 61 ++++++
 rtl/pwm8_servo_core.sv | 162 ++++++++++++++++
 tb/tb_pwm8_servo_core.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm8_pkg.sv
// rtl/pwm8_pkg.sv - shared constants and slew helper for the pwm8 servo core (PWM_SOFTSTART_EN uses slew_step)
package pwm8_pkg;

  localparam int CNT_W_DEF        = 16;
  localparam int PRESCALE_RST_DEF = 49;
  localparam int PERIOD_RST_DEF   = 19999;
  localparam int DUTY_RST_DEF     = 1500;
  localparam int SLEW_RST_DEF     = 10;

  localparam logic [7:0] ADDR_DUTY0    = 8'h00;
  localparam logic [7:0] ADDR_DUTY7    = 8'h07;
  localparam logic [7:0] ADDR_PERIOD   = 8'h08;
  localparam logic [7:0] ADDR_PRESCALE = 8'h09;
  localparam logic [7:0] ADDR_ENABLE   = 8'h0A;
  localparam logic [7:0] ADDR_CTRL     = 8'h0B;
  localparam logic [7:0] ADDR_FRAMECNT = 8'h0C;
  localparam logic [7:0] ADDR_SLEW     = 8'h0D;

  // Move cur toward tgt by at most slew; slew of zero jumps straight to tgt.
  function automatic logic [31:0] slew_step(input logic [31:0] cur,
                                            input logic [31:0] tgt,
                                            input logic [31:0] slew);
    if (slew == 32'd0) return tgt;
    if (tgt > cur) return ((tgt - cur) > slew) ? cur + slew : tgt;
    return ((cur - tgt) > slew) ? cur - slew : tgt;
  endfunction

endpackage

// File: rtl/pwm8_timebase.sv
// rtl/pwm8_timebase.sv - prescaler, period counter, frame_start and FRAMECNT with SYNC restart
module pwm8_timebase #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] prescale,
  input  logic             prescale_wr,
  input  logic             sync,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] count,
  output logic             boundary,
  output logic             frame_start,
  output logic [CNT_W-1:0] framecnt
);

  logic [CNT_W-1:0] pre;
  logic             tick;
  logic             wrap;

  // Tick on the last prescaler step; a wrap is a tick at the end of the period that SYNC does not override.
  always_comb begin
    tick     = (pre >= prescale);
    wrap     = tick && (count >= period) && !sync;
    boundary = sync || wrap;
  end

  // Prescaler restarts on SYNC, on a PRESCALE write, and after every tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
    end else if (sync || prescale_wr || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Period counter walks 0..period on ticks; SYNC wins over a coincident tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (sync) begin
      count <= '0;
    end else if (tick) begin
      count <= (count >= period) ? '0 : count + 1'b1;
    end
  end

  // frame_start marks every boundary; FRAMECNT only counts natural wraps and rolls over freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_start <= 1'b0;
      framecnt    <= '0;
    end else begin
      frame_start <= boundary;
      if (wrap) framecnt <= framecnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm8_servo_core.sv
// rtl/pwm8_servo_core.sv - 8-channel servo PWM top: register file, shadows, compare; PWM_SOFTSTART_EN adds SLEW
module pwm8_servo_core
  import pwm8_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int PRESCALE_RST = PRESCALE_RST_DEF,
  parameter int PERIOD_RST   = PERIOD_RST_DEF,
  parameter int DUTY_RST     = DUTY_RST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] d_in,
  input  logic [7:0]       addr,
  input  logic             rd,
  input  logic             wr,
  output logic [CNT_W-1:0] d_out,
  output logic             frame_start,
  output logic             pwm0,
  output logic             pwm1,
  output logic             pwm2,
  output logic             pwm3,
  output logic             pwm4,
  output logic             pwm5,
  output logic             pwm6,
  output logic             pwm7
);

  logic [CNT_W-1:0] duty    [8];
  logic [CNT_W-1:0] duty_sh [8];
  logic [CNT_W-1:0] duty_nx [8];
  logic [CNT_W-1:0] duty_ld [8];
  logic [CNT_W-1:0] period, period_sh, period_nx, prescale, count, framecnt, rdata;
  logic [7:0]       enable, en_sh, enable_nx, en_eff, pwm_q;
  logic             wr_duty, wr_period, wr_prescale, wr_enable, sync, boundary;
`ifdef PWM_SOFTSTART_EN
  logic [CNT_W-1:0] slew;
  logic             wr_slew;
`endif

  // Write decode and next-value view of the live registers, so a write coinciding with a boundary is captured.
  always_comb begin
    wr_duty     = wr && (addr <= ADDR_DUTY7);
    wr_period   = wr && (addr == ADDR_PERIOD);
    wr_prescale = wr && (addr == ADDR_PRESCALE);
    wr_enable   = wr && (addr == ADDR_ENABLE);
    sync        = wr && (addr == ADDR_CTRL) && d_in[0];
    period_nx   = wr_period ? d_in : period;
    enable_nx   = wr_enable ? d_in[7:0] : enable;
    en_eff      = en_sh & (wr_enable ? d_in[7:0] : 8'hFF);
    for (int i = 0; i < 8; i++) begin
      duty_nx[i] = (wr_duty && (addr[2:0] == i[2:0])) ? d_in : duty[i];
    end
  end

  // Value each duty shadow takes at a boundary: direct load, or a slew-limited step outside SYNC.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
`ifdef PWM_SOFTSTART_EN
      duty_ld[i] = sync ? duty_nx[i]
                        : CNT_W'(slew_step(32'(duty_sh[i]), 32'(duty_nx[i]), 32'(slew)));
`else
      duty_ld[i] = duty_nx[i];
`endif
    end
  end

  // Live register file; unmapped writes fall through untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) duty[i] <= CNT_W'(DUTY_RST);
      period   <= CNT_W'(PERIOD_RST);
      prescale <= CNT_W'(PRESCALE_RST);
      enable   <= '0;
    end else begin
      for (int i = 0; i < 8; i++) duty[i] <= duty_nx[i];
      period <= period_nx;
      enable <= enable_nx;
      if (wr_prescale) prescale <= d_in;
    end
  end

`ifdef PWM_SOFTSTART_EN
  assign wr_slew = wr && (addr == ADDR_SLEW);

  // SLEW register, present only with soft start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slew <= CNT_W'(SLEW_RST_DEF);
    end else if (wr_slew) begin
      slew <= d_in;
    end
  end
`endif

  // Shadows load at boundaries; clearing an ENABLE bit drops the shadow bit at once, setting one waits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) duty_sh[i] <= CNT_W'(DUTY_RST);
      period_sh <= CNT_W'(PERIOD_RST);
      en_sh     <= '0;
    end else if (boundary) begin
      for (int i = 0; i < 8; i++) duty_sh[i] <= duty_ld[i];
      period_sh <= period_nx;
      en_sh     <= enable_nx;
    end else if (wr_enable) begin
      en_sh <= en_sh & d_in[7:0];
    end
  end

  // Registered compare; a same-cycle disable write masks the channel so it drops on the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_q <= '0;
    end else begin
      for (int i = 0; i < 8; i++) pwm_q[i] <= en_eff[i] && (count < duty_sh[i]);
    end
  end

  // Read mux over the pre-write register values.
  always_comb begin
    rdata = '0;
    if (addr <= ADDR_DUTY7) begin
      rdata = duty[addr[2:0]];
    end else begin
      case (addr)
        ADDR_PERIOD:   rdata = period;
        ADDR_PRESCALE: rdata = prescale;
        ADDR_ENABLE:   rdata = {{(CNT_W-8){1'b0}}, enable};
        ADDR_FRAMECNT: rdata = framecnt;
`ifdef PWM_SOFTSTART_EN
        ADDR_SLEW:     rdata = slew;
`endif
        default:       rdata = '0;
      endcase
    end
  end

  // Read data register holds until the next read strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out <= '0;
    end else if (rd) begin
      d_out <= rdata;
    end
  end

  pwm8_timebase #(.CNT_W(CNT_W)) u_timebase (
    .clk         (clk),
    .rst         (rst),
    .prescale    (prescale),
    .prescale_wr (wr_prescale),
    .sync        (sync),
    .period      (period_sh),
    .count       (count),
    .boundary    (boundary),
    .frame_start (frame_start),
    .framecnt    (framecnt)
  );

  assign {pwm7, pwm6, pwm5, pwm4, pwm3, pwm2, pwm1, pwm0} = pwm_q;

endmodule

// File: tb/tb_pwm8_servo_core.sv
// tb/tb_pwm8_servo_core.sv - scoreboard bench for pwm8_servo_core (soft-start expectations under PWM_SOFTSTART_EN)
`timescale 1ns/1ps
module tb_pwm8_servo_core;

`ifdef PWM_SOFTSTART_EN
  localparam int SLEW_RST_EXP = 10;
  localparam int W0_LAST      = 9;
`else
  localparam int SLEW_RST_EXP = 0;
  localparam int W0_LAST      = 7;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] d_in = '0;
  logic [7:0]  addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  wire  [15:0] d_out;
  wire         frame_start;
  wire         pwm0, pwm1, pwm2, pwm3, pwm4, pwm5, pwm6, pwm7;
  wire  [7:0]  pwm_bus = {pwm7, pwm6, pwm5, pwm4, pwm3, pwm2, pwm1, pwm0};

  always #5 clk = ~clk;

  pwm8_servo_core dut (
    .clk(clk), .rst(rst), .d_in(d_in), .addr(addr), .rd(rd), .wr(wr),
    .d_out(d_out), .frame_start(frame_start),
    .pwm0(pwm0), .pwm1(pwm1), .pwm2(pwm2), .pwm3(pwm3),
    .pwm4(pwm4), .pwm5(pwm5), .pwm6(pwm6), .pwm7(pwm7)
  );

  typedef struct {
    int len;
    int w0;
    int w1;
    int w2;
    int wrest;
  } frame_exp_t;

  frame_exp_t frame_q[$];
  int         rd_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       rd_at_edge = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input int len, input int w0, input int w1, input int w2, input int wrest);
    frame_exp_t e;
    e.len = len; e.w0 = w0; e.w1 = w1; e.w2 = w2; e.wrest = wrest;
    frame_q.push_back(e);
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [15:0] v);
    addr = a; d_in = v; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, input int exp);
    addr = a; rd = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic reg_rd_wr(input logic [7:0] a, input logic [15:0] v, input int exp);
    addr = a; d_in = v; wr = 1'b1; rd = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("frame_start_seen", int'(frame_start), 1);
    #1;
  endtask

  always @(posedge clk) rd_at_edge <= rd;

  // Monitor: read data after each strobe, and per-frame pwm widths closed at each frame_start.
  initial begin
    int acc_len;
    int acc_w[8];
    int rest;
    int idx;
    frame_exp_t e;
    acc_len = 0;
    idx = 0;
    for (int i = 0; i < 8; i++) acc_w[i] = 0;
    forever begin
      @(negedge clk);
      if (rd_at_edge && rd_q.size() > 0) check("d_out", int'(d_out), rd_q.pop_front());
      acc_len++;
      for (int i = 0; i < 8; i++) if (pwm_bus[i]) acc_w[i]++;
      if (frame_start) begin
        if (frame_q.size() > 0) begin
          e = frame_q.pop_front();
          idx++;
          rest = 0;
          for (int i = 3; i < 8; i++) rest += acc_w[i];
          check($sformatf("frame%0d_len", idx), acc_len, e.len);
          check($sformatf("frame%0d_pwm0_width", idx), acc_w[0], e.w0);
          check($sformatf("frame%0d_pwm1_width", idx), acc_w[1], e.w1);
          check($sformatf("frame%0d_pwm2_width", idx), acc_w[2], e.w2);
          check($sformatf("frame%0d_pwm3to7_width", idx), rest, e.wrest);
        end
        acc_len = 0;
        for (int i = 0; i < 8; i++) acc_w[i] = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm_bus), 0);
    check("reset_d_out", int'(d_out), 0);
    check("reset_frame_start", int'(frame_start), 0);
    rst = 1'b1;
    @(negedge clk);

    reg_read(8'h00, 1500);
    reg_read(8'h07, 1500);
    reg_read(8'h08, 19999);
    reg_read(8'h09, 49);
    reg_read(8'h0A, 0);
    reg_read(8'h0B, 0);
    reg_read(8'h0C, 0);
    reg_read(8'h0D, SLEW_RST_EXP);
    reg_read(8'h20, 0);

    reg_write(8'h09, 16'd0);
    reg_write(8'h08, 16'd9);
    reg_write(8'h00, 16'd3);
    reg_write(8'h01, 16'd0);
    reg_write(8'h02, 16'd12);
    reg_write(8'h0A, 16'h0001);
    reg_write(8'h0B, 16'h0001);
    check("sync_frame_start", int'(frame_start), 1);
    #1;
    repeat (5) push_frame(10, 3, 0, 0, 0);
    repeat (5) wait_fs();
    reg_read(8'h0C, 5);

    reg_write(8'h0A, 16'h0006);
    wait_fs();
    repeat (2) push_frame(10, 0, 0, 10, 0);
    repeat (2) wait_fs();

    reg_write(8'h0A, 16'h0001);
    wait_fs();
    push_frame(10, 3, 0, 0, 0);
    push_frame(10, 7, 0, 0, 0);
    repeat (2) @(negedge clk);
    reg_write(8'h00, 16'd7);
    repeat (2) wait_fs();

    push_frame(10, 1, 0, 0, 0);
    push_frame(10, 7, 0, 0, 0);
    @(negedge clk);
    check("pwm0_high_before_disable", int'(pwm0), 1);
    reg_write(8'h0A, 16'h0000);
    check("pwm0_low_after_disable", int'(pwm0), 0);
    reg_write(8'h0A, 16'h0001);
    check("pwm0_enable_waits", int'(pwm0), 0);
    repeat (2) wait_fs();

`ifdef PWM_SOFTSTART_EN
    reg_write(8'h0D, 16'd2);
    reg_write(8'h00, 16'd3);
    reg_write(8'h0B, 16'h0001);
    check("sync2_frame_start", int'(frame_start), 1);
    #1;
    push_frame(10, 3, 0, 0, 0);
    push_frame(10, 5, 0, 0, 0);
    push_frame(10, 7, 0, 0, 0);
    push_frame(10, 9, 0, 0, 0);
    push_frame(10, 9, 0, 0, 0);
    reg_write(8'h00, 16'd9);
    repeat (5) wait_fs();
`else
    reg_write(8'h0D, 16'd5);
    reg_read(8'h0D, 0);
    reg_write(8'h20, 16'd7);
    reg_read(8'h20, 0);
`endif

    reg_rd_wr(8'h08, 16'd20, 9);
    reg_read(8'h08, 20);
    wait_fs();
    push_frame(21, W0_LAST, 0, 0, 0);
    wait_fs();

    @(negedge clk);
    check("pwm0_high_before_reset", int'(pwm0), 1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm_bus), 0);
    check("async_reset_d_out", int'(d_out), 0);
    check("async_reset_frame_start", int'(frame_start), 0);
    @(negedge clk);
    rst = 1'b1;
    reg_read(8'h0C, 0);
    reg_read(8'h08, 19999);
    repeat (3) @(negedge clk);
    check("frame_queue_drained", frame_q.size(), 0);
    check("read_queue_drained", rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
